tnoc_axi_write_read_scheduler: RTL and testbench
================================================

# tnoc_axi_write_read_scheduler

Packet-granular scheduler that shares one local `flit_out_if` between the write-request and read-request flit streams of an AXI slave adapter. It applies weighted round-robin between the two streams and locks the grant from head flit to tail flit. It also enforces a per-direction outstanding-request limit, using response-completion pulses from the response-side demux. It drops in between the write/read adapters and the router local port, in place of a plain mux.

## Interface
Parameters:
- `CONFIG`, `TNOC_DEFAULT_CONFIG`: NoC configuration; flit format and `virtual_channels`.
- `WRITE_WEIGHT`, 1: consecutive write packets granted per turn (1..15).
- `READ_WEIGHT`, 1: consecutive read packets granted per turn (1..15).
- `MAX_OUTSTANDING`, 8: maximum issued-but-unanswered packets per direction (1..255).
- localparam `CNT_WIDTH` = `$clog2(MAX_OUTSTANDING+1)`.

Ports:
- `clk`  input  1  clock.
- `rst_n`  input  1  reset; one clock, asynchronous, active-low.
- `write_flit_if`  `tnoc_flit_if.target`  —  write request flits (1 channel, local port).
- `read_flit_if`  `tnoc_flit_if.target`  —  read request flits.
- `flit_out_if`  `tnoc_flit_if.initiator`  —  merged request flits to the router.
- `i_write_done`  input  1  one-cycle pulse: tail flit of a write response consumed.
- `i_read_done`  input  1  one-cycle pulse: tail flit of a read response consumed.
- `o_write_outstanding`  output  `CNT_WIDTH`  current write outstanding count.
- `o_read_outstanding`  output  `CNT_WIDTH`  current read outstanding count.
- `o_busy`  output  1  high while the FSM is in a packet-locked state.

## Operation
- FSM states are `IDLE`, `WRITE`, `READ`.
- `IDLE` evaluates eligibility:
  - write is eligible when `write_flit_if` is valid with a head flit and `write_count < MAX_OUTSTANDING`.
  - read eligibility is defined the same way.
- `IDLE` chooses the direction from eligibility and the turn pointer:
  - If only one direction is eligible, it is chosen.
  - If both are eligible, the direction named by the turn pointer `turn` is chosen.
- In `IDLE` the grant is combinational: the head flit passes through in the same cycle.
- If the head flit is accepted (valid & ready) and it is also the tail (single-flit packet), the FSM stays in `IDLE`. Otherwise it moves to the chosen state.
- `WRITE`/`READ` states:
  - Only the granted stream is connected (valid, flit and ready).
  - The other stream's ready is held 0.
  - The FSM returns to `IDLE` when the tail flit is accepted.
- Packet issue, counted on head-flit acceptance:
  - The direction's outstanding counter increments.
  - The weight counter `wcnt` increments.
- Weight handling:
  - When `wcnt` reaches the current direction's weight, `turn` flips and `wcnt` clears.
  - When the direction not named by `turn` is granted because `turn`'s direction is not eligible, `turn` flips to the granted direction and `wcnt` is set to 1.
- Outstanding counters:
  - A done pulse decrements the direction's counter.
  - Increment and decrement in the same cycle leave the counter unchanged.
  - A done pulse at count 0 is ignored. The counter saturates at 0 and never wraps; an assertion flags it.
- Limit: at `MAX_OUTSTANDING`, new heads of that direction are blocked. A packet already in progress always completes.
- Non-head flit valid in `IDLE` is a protocol error: it is not forwarded and an assertion fires.
- Reset mid-packet: all state clears, the FSM returns to `IDLE`, and counters go to 0. Upstream adapters reset on the same `rst_n`.

## Timing
- Reset values:
  - `flit_out_if` valid = 0.
  - Both target readies = 0.
  - `o_write_outstanding` = 0, `o_read_outstanding` = 0.
  - `o_busy` = 0.
  - `turn` = write, `wcnt` = 0.
- Zero-cycle latency: `flit_out_if` valid/flit is combinational from the granted source. Target ready = `flit_out_if` ready & grant.
- Once the output is valid, the flit is held stable until ready. This follows from the upstream flit_if rules and a grant that does not change mid-packet.
- No bubble between back-to-back packets: a tail accept in a locked state and a new head grant in `IDLE` occur on consecutive cycles.
- Counter outputs are registered and change the cycle after the event.

## Structure
- State enum `tnoc_axi_scheduler_state` and direction enum (`WRITE`, `READ`) go in the shared tnoc package.
- Sub-module `tnoc_outstanding_counter` (parameter `MAX`; inputs inc/dec; outputs count and full) is instantiated twice.
- FSM, turn and weight logic stay in the top module.

## Test plan
- **Reset mid-packet.** Assert `rst_n` low during the second flit of a 4-flit write packet. Required: valid = 0, counters = 0, FSM in `IDLE`. After release, a fresh single-flit read is forwarded the same cycle it arrives.
- **Continuous traffic, default weights.** Both streams continuously offer single-flit packets, `WRITE_WEIGHT`=`READ_WEIGHT`=1, `MAX_OUTSTANDING`=8, done pulses each cycle. Required order on `flit_out_if`: W,R,W,R… with one flit per cycle.
- **Weighted round-robin.** `WRITE_WEIGHT`=3, `READ_WEIGHT`=1, both streams always eligible. Required pattern: W,W,W,R repeating.
- **Packet lock.** Start a 4-flit write packet; a read head arrives on cycle 2. Required: read ready stays 0 until the write tail is accepted, and the read head is forwarded on the next cycle.
- **Outstanding limit.** `MAX_OUTSTANDING`=2, issue 3 write packets, no done pulses. Required: the third head is stalled and `o_write_outstanding`=2. After one `i_write_done`, the third head is forwarded and the count stays 2.
- **Simultaneous inc/dec and underflow.** Pulse `i_read_done` in the same cycle a read head is accepted at count 1: count stays 1. Pulse `i_read_done` at count 0: count stays 0 and the assertion fires.

Source files
------------

// File: rtl/tnoc_axi_write_read_scheduler_pkg.sv
// Shared types for the AXI request-side scheduler: NoC config, flit format,
// stream direction and FSM state encoding.
package tnoc_axi_write_read_scheduler_pkg;

  typedef struct packed {
    int virtual_channels;
    int data_width;
  } tnoc_config_t;

  localparam int FLIT_DATA_WIDTH = 32;

  localparam tnoc_config_t TNOC_DEFAULT_CONFIG = '{virtual_channels: 1, data_width: FLIT_DATA_WIDTH};

  typedef struct packed {
    logic                       head;
    logic                       tail;
    logic [FLIT_DATA_WIDTH-1:0] data;
  } tnoc_flit_t;

  typedef enum logic {
    DIR_WRITE = 1'b0,
    DIR_READ  = 1'b1
  } tnoc_axi_direction;

  typedef logic [1:0] tnoc_axi_scheduler_state;

  localparam tnoc_axi_scheduler_state ST_IDLE  = 2'd0;
  localparam tnoc_axi_scheduler_state ST_WRITE = 2'd1;
  localparam tnoc_axi_scheduler_state ST_READ  = 2'd2;

  function automatic tnoc_axi_direction other_dir(tnoc_axi_direction d);
    return (d == DIR_WRITE) ? DIR_READ : DIR_WRITE;
  endfunction

endpackage

// File: rtl/tnoc_axi_write_read_scheduler_if.sv
// Single-channel flit link: initiator drives valid/flit, target returns ready.
interface tnoc_flit_if;
  import tnoc_axi_write_read_scheduler_pkg::*;

  logic       valid;
  logic       ready;
  tnoc_flit_t flit;

  modport initiator (output valid, output flit, input ready);
  modport target    (input valid, input flit, output ready);

endinterface

// File: rtl/tnoc_axi_write_read_scheduler_counter.sv
// Outstanding-request counter: +1 on issue, -1 on completion, saturates at 0.
module tnoc_outstanding_counter #(
  parameter int MAX = 8,
  localparam int WIDTH = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && count != WIDTH'(MAX)) begin
      count <= count + WIDTH'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign full = (count == WIDTH'(MAX));

  // A completion with nothing outstanding is dropped rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst_n && dec && !inc) begin
      assert (count != '0) else $warning("done pulse with zero outstanding ignored");
    end
  end

endmodule

// File: rtl/tnoc_axi_write_read_scheduler.sv
// Packet-locked weighted round-robin between write and read request flit
// streams onto one local port, with per-direction outstanding limits.
//   state    | meaning
//   ST_IDLE  | no packet locked; head grant is combinational
//   ST_WRITE | write packet locked until its tail is accepted
//   ST_READ  | read packet locked until its tail is accepted
module tnoc_axi_write_read_scheduler
  import tnoc_axi_write_read_scheduler_pkg::*;
#(
  parameter tnoc_config_t CONFIG          = TNOC_DEFAULT_CONFIG,
  parameter int           WRITE_WEIGHT    = 1,
  parameter int           READ_WEIGHT     = 1,
  parameter int           MAX_OUTSTANDING = 8,
  localparam int          CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tnoc_flit_if.target          write_flit_if,
  tnoc_flit_if.target          read_flit_if,
  tnoc_flit_if.initiator       flit_out_if,
  input  logic                 i_write_done,
  input  logic                 i_read_done,
  output logic [CNT_WIDTH-1:0] o_write_outstanding,
  output logic [CNT_WIDTH-1:0] o_read_outstanding,
  output logic                 o_busy
);

  tnoc_axi_scheduler_state state, state_next;
  tnoc_axi_direction       turn, issue_dir;
  logic [3:0]              wcnt, wcnt_next, weight;
  logic write_full, read_full, write_eligible, read_eligible;
  logic select_write, select_read, grant_write, grant_read;
  logic accept_write, accept_read, issue_write, issue_read;

  assign write_eligible = write_flit_if.valid && write_flit_if.flit.head && !write_full;
  assign read_eligible  = read_flit_if.valid  && read_flit_if.flit.head  && !read_full;
  assign select_write   = write_eligible && (!read_eligible || turn == DIR_WRITE);
  assign select_read    = read_eligible && !select_write;

  assign grant_write = (state == ST_WRITE) || (state == ST_IDLE && select_write);
  assign grant_read  = (state == ST_READ)  || (state == ST_IDLE && select_read);

  assign flit_out_if.valid = (grant_write && write_flit_if.valid) || (grant_read && read_flit_if.valid);
  assign flit_out_if.flit  = grant_read ? read_flit_if.flit : write_flit_if.flit;
  assign write_flit_if.ready = flit_out_if.ready && grant_write;
  assign read_flit_if.ready  = flit_out_if.ready && grant_read;

  assign accept_write = write_flit_if.valid && write_flit_if.ready;
  assign accept_read  = read_flit_if.valid  && read_flit_if.ready;
  assign issue_write  = accept_write && write_flit_if.flit.head;
  assign issue_read   = accept_read  && read_flit_if.flit.head;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (select_write && !(accept_write && write_flit_if.flit.tail)) state_next = ST_WRITE;
        else if (select_read && !(accept_read && read_flit_if.flit.tail)) state_next = ST_READ;
      end
      ST_WRITE: if (accept_write && write_flit_if.flit.tail) state_next = ST_IDLE;
      ST_READ:  if (accept_read && read_flit_if.flit.tail) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Granting the off-turn direction restarts its quota at one packet.
  assign issue_dir = issue_read ? DIR_READ : DIR_WRITE;
  assign weight    = (issue_dir == DIR_WRITE) ? 4'(WRITE_WEIGHT) : 4'(READ_WEIGHT);
  assign wcnt_next = (issue_dir == turn) ? wcnt + 4'd1 : 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      turn  <= DIR_WRITE;
      wcnt  <= '0;
    end else begin
      state <= state_next;
      if (issue_write || issue_read) begin
        if (wcnt_next >= weight) begin
          turn <= other_dir(issue_dir);
          wcnt <= '0;
        end else begin
          turn <= issue_dir;
          wcnt <= wcnt_next;
        end
      end
    end
  end

  assign o_busy = (state != ST_IDLE);

  tnoc_outstanding_counter #(.MAX(MAX_OUTSTANDING)) u_write_cnt (
    .clk(clk), .rst_n(rst_n), .inc(issue_write), .dec(i_write_done),
    .count(o_write_outstanding), .full(write_full)
  );

  tnoc_outstanding_counter #(.MAX(MAX_OUTSTANDING)) u_read_cnt (
    .clk(clk), .rst_n(rst_n), .inc(issue_read), .dec(i_read_done),
    .count(o_read_outstanding), .full(read_full)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (CONFIG.virtual_channels == 1 && CONFIG.data_width == FLIT_DATA_WIDTH)
        else $error("unsupported NoC configuration");
      assert (!(state == ST_IDLE && write_flit_if.valid && !write_flit_if.flit.head))
        else $error("non-head write flit offered with no packet in progress");
      assert (!(state == ST_IDLE && read_flit_if.valid && !read_flit_if.flit.head))
        else $error("non-head read flit offered with no packet in progress");
    end
  end

endmodule

// File: tb/tb_tnoc_axi_write_read_scheduler.sv
// Randomized scoreboard bench: packet-level arbitration model vs. the scheduler.
module tb_tnoc_axi_write_read_scheduler;
  import tnoc_axi_write_read_scheduler_pkg::*;

  localparam int WW   = 3;
  localparam int RW   = 1;
  localparam int MAXO = 2;
  localparam int CW   = $clog2(MAXO + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tnoc_flit_if wr_if ();
  tnoc_flit_if rd_if ();
  tnoc_flit_if out_if ();
  logic          write_done, read_done, busy;
  logic [CW-1:0] w_out, r_out;

  tnoc_axi_write_read_scheduler #(
    .WRITE_WEIGHT(WW), .READ_WEIGHT(RW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .write_flit_if(wr_if), .read_flit_if(rd_if), .flit_out_if(out_if),
    .i_write_done(write_done), .i_read_done(read_done),
    .o_write_outstanding(w_out), .o_read_outstanding(r_out), .o_busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic tnoc_flit_t make_flit(int d, int s, int i, int l);
    tnoc_flit_t fl;
    fl.head = (i == 0);
    fl.tail = (i == l - 1);
    fl.data = {8'(d), 8'(s), 8'(i), 8'(l)};
    return fl;
  endfunction

  // stimulus knobs and source state (index 0 = write, 1 = read)
  int offer[2];
  int minlen, maxlen, ready_pct, done_pct;
  bit force_wr_done, force_rd_done;
  bit active[2];
  int idx[2], len[2], seq[2];
  bit acc[2];
  tnoc_flit_t exp_q[2][$];

  // reference model state
  int cur;
  int m_cnt[2];
  int m_turn, m_wcnt;

  task automatic drive_step();
    for (int d = 0; d < 2; d++) begin
      if (acc[d]) begin
        if (idx[d] == len[d] - 1) active[d] = 1'b0;
        else idx[d]++;
      end
      if (!active[d] && int'($urandom_range(99)) < offer[d]) begin
        active[d] = 1'b1;
        idx[d]    = 0;
        len[d]    = int'($urandom_range(maxlen, minlen));
        seq[d]++;
        for (int i = 0; i < len[d]; i++) exp_q[d].push_back(make_flit(d, seq[d], i, len[d]));
      end
    end
    wr_if.valid  = active[0];
    wr_if.flit   = active[0] ? make_flit(0, seq[0], idx[0], len[0]) : '0;
    rd_if.valid  = active[1];
    rd_if.flit   = active[1] ? make_flit(1, seq[1], idx[1], len[1]) : '0;
    out_if.ready = int'($urandom_range(99)) < ready_pct;
    write_done   = force_wr_done || (m_cnt[0] > 0 && int'($urandom_range(99)) < done_pct);
    read_done    = force_rd_done || (m_cnt[1] > 0 && int'($urandom_range(99)) < done_pct);
  endtask

  task automatic sample_acc();
    acc[0] = wr_if.valid && wr_if.ready;
    acc[1] = rd_if.valid && rd_if.ready;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive_step();
    @(negedge clk);
    sample_acc();
  endtask

  // monitor: predicts the granted packet and compares the merged stream
  logic       v[2], rdy[2], dn[2], inc[2], elig[2];
  tnoc_flit_t f[2];
  int         d, nw;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_if.valid, 1'b0);
      check("rst_wr_ready", wr_if.ready, 1'b0);
      check("rst_rd_ready", rd_if.ready, 1'b0);
      check("rst_w_count", w_out, 0);
      check("rst_r_count", r_out, 0);
      check("rst_busy", busy, 1'b0);
      cur = -1; m_cnt = '{0, 0}; m_turn = 0; m_wcnt = 0;
      exp_q[0].delete(); exp_q[1].delete();
    end else begin
      v[0] = wr_if.valid;  f[0] = wr_if.flit;  rdy[0] = wr_if.ready; dn[0] = write_done;
      v[1] = rd_if.valid;  f[1] = rd_if.flit;  rdy[1] = rd_if.ready; dn[1] = read_done;
      inc = '{1'b0, 1'b0};
      check("busy", busy, cur >= 0);
      check("w_count", w_out, m_cnt[0]);
      check("r_count", r_out, m_cnt[1]);
      if (cur < 0) begin
        for (int k = 0; k < 2; k++) elig[k] = v[k] && f[k].head && m_cnt[k] < MAXO;
        if (elig[0] && elig[1]) cur = m_turn;
        else if (elig[0]) cur = 0;
        else if (elig[1]) cur = 1;
      end
      if (cur < 0) begin
        check("idle_out_valid", out_if.valid, 1'b0);
        check("idle_wr_ready", rdy[0], 1'b0);
        check("idle_rd_ready", rdy[1], 1'b0);
      end else begin
        d = cur;
        check("out_valid", out_if.valid, v[d]);
        if (v[d] && exp_q[d].size() > 0) check("out_flit", out_if.flit, exp_q[d][0]);
        check("granted_ready", rdy[d], out_if.ready);
        check("blocked_ready", rdy[1-d], 1'b0);
        if (v[d] && out_if.ready) begin
          if (exp_q[d].size() > 0) void'(exp_q[d].pop_front());
          if (f[d].head) begin
            inc[d] = 1'b1;
            nw = (d == m_turn) ? m_wcnt + 1 : 1;
            if (nw >= ((d == 0) ? WW : RW)) begin m_turn = 1 - d; m_wcnt = 0; end
            else begin m_turn = d; m_wcnt = nw; end
          end
          if (f[d].tail) cur = -1;
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (inc[k] && !dn[k]) m_cnt[k]++;
        else if (dn[k] && !inc[k] && m_cnt[k] > 0) m_cnt[k]--;
      end
    end
  end

  task automatic drain();
    offer = '{0, 0}; ready_pct = 100; done_pct = 100;
    repeat (12) cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    wr_if.valid = 1'b0; wr_if.flit = '0; rd_if.valid = 1'b0; rd_if.flit = '0;
    out_if.ready = 1'b0; write_done = 1'b0; read_done = 1'b0;
    offer = '{0, 0}; minlen = 1; maxlen = 1; ready_pct = 0; done_pct = 0;
    force_wr_done = 1'b0; force_rd_done = 1'b0;
    active = '{1'b0, 1'b0}; idx = '{0, 0}; len = '{1, 1}; seq = '{0, 0}; acc = '{1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // continuous single-flit traffic on both streams, weighted turns
    offer = '{100, 100}; minlen = 1; maxlen = 1; ready_pct = 100; done_pct = 100;
    repeat (40) cycle();

    // multi-flit packets: packet lock and back-to-back grants
    minlen = 1; maxlen = 4;
    repeat (200) cycle();
    drain();

    // outstanding limit on writes
    offer = '{100, 0}; minlen = 1; maxlen = 1; done_pct = 0;
    repeat (8) cycle();
    check("limit_count", w_out, MAXO);
    check("limit_stall_valid", out_if.valid, 1'b0);
    check("limit_stall_ready", wr_if.ready, 1'b0);
    force_wr_done = 1'b1; cycle(); force_wr_done = 1'b0;
    cycle();
    check("limit_release_valid", out_if.valid, 1'b1);
    check("limit_release_ready", wr_if.ready, 1'b1);
    cycle();
    check("limit_recount", w_out, MAXO);
    drain();

    // random mix of everything
    offer = '{60, 60}; minlen = 1; maxlen = 4; ready_pct = 70; done_pct = 40;
    repeat (3000) cycle();
    drain();

    // issue and completion in the same cycle at count 1
    offer = '{0, 100}; minlen = 1; maxlen = 1; done_pct = 0;
    cycle();
    force_rd_done = 1'b1; cycle(); force_rd_done = 1'b0;
    offer = '{0, 0};
    cycle();
    check("incdec_count", r_out, 1);
    drain();

    // completion with nothing outstanding
    done_pct = 0;
    force_rd_done = 1'b1; cycle(); force_rd_done = 1'b0;
    cycle();
    check("underflow_count", r_out, 0);

    // reset during the second flit of a 4-flit write
    offer = '{100, 0}; minlen = 4; maxlen = 4; ready_pct = 100;
    for (int k = 0; k < 20 && !(active[0] && idx[0] == 1); k++) cycle();
    check("mid_packet_reached", active[0] && idx[0] == 1, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0; offer = '{0, 0}; active = '{1'b0, 1'b0}; acc = '{1'b0, 1'b0};
    wr_if.valid = 1'b0; rd_if.valid = 1'b0; write_done = 1'b0; read_done = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", out_if.valid, 1'b0);
    check("mid_rst_count", w_out, 0);
    check("mid_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; offer = '{0, 100}; minlen = 1; maxlen = 1;
    drive_step();
    @(negedge clk);
    check("post_rst_read_valid", out_if.valid, 1'b1);
    check("post_rst_read_ready", rd_if.ready, 1'b1);
    check("post_rst_read_head", out_if.flit.head, 1'b1);
    sample_acc();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
